cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
Controller that sits directly upstream of the 32-entry direct-mapped cache (8-bit tag, 64-bit block, valid/dirty metadata). It accepts 16-bit processor load/store requests, performs tag compare against the cache's read port, and drives the cache write port on store hits and line fills. On a miss it runs write-back (dirty victim) and block fill against a block-wide memory handshake.

Parameters:
CNT_W, 16, width of hit and miss statistics counters; counters wrap.
Field widths are fixed by the cache geometry (tag 8, index 5, word offset 2, word 16, block 64) and are not parameters.

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
cpu_req  in  1  request strobe; sampled only in IDLE
cpu_wr  in  1  1 = store, 0 = load
cpu_addr  in  16  byte address: [15:8] tag, [7:3] index, [2:1] word, [0] ignored
cpu_wdata  in  16  store data
cpu_busy  out  1  high whenever state is not IDLE (combinational)
cpu_done  out  1  one-cycle completion pulse (registered)
cpu_rdata  out  16  load data, valid while cpu_done=1 (registered)
c_index  out  5  to cache inIndex
c_tag  out  8  to cache inTag
c_dirty  out  1  to cache inDirty
c_block  out  64  to cache inBlock
c_wr  out  1  to cache wr
c_otag  in  8  from cache outTag
c_oblock  in  64  from cache outBlock
c_ovalid  in  1  from cache outValid
c_odirty  in  1  from cache outDirty
mem_req  out  1  memory request, held until mem_ack
mem_wr  out  1  1 = block write-back, 0 = block fill
mem_addr  out  13  block address {tag, index}
mem_wdata  out  64  write-back block
mem_rdata  in  64  fill block, valid with mem_ack
mem_ack  in  1  one-cycle acknowledge; never asserted without mem_req
hit_cnt  out  CNT_W  completed hits
miss_cnt  out  CNT_W  detected misses

Behaviour:
- Reset (rstn low at an edge): state IDLE; cpu_done 0, cpu_rdata 0, mem_req 0, mem_wr 0, hit_cnt 0, miss_cnt 0; latched request registers 0. c_wr is 0 in every state except the write cycles below. Reset mid-transaction abandons it; mem_req is low from the reset edge onward, and the memory side must drop the orphaned request.
- Word lanes: word w occupies block bits [16w+15:16w]. Merge replaces lane cpu_addr[2:1] with wdata and keeps the other lanes.
- c_index = latched index in all states. No cache writes in IDLE.
- Hit = c_ovalid and (c_otag == latched tag).
- States: IDLE, LOOKUP, WB, FILL.
- IDLE: if cpu_req, latch addr, wr and wdata, then go to LOOKUP. cpu_done is cleared every cycle unless set by a completion.
- LOOKUP, hit load: cpu_rdata <= selected lane of c_oblock; cpu_done <= 1; hit_cnt++; next state IDLE.
- LOOKUP, hit store: c_wr=1, c_tag=latched tag, c_dirty=1, c_block=merge(c_oblock); cpu_done <= 1; cpu_rdata unchanged; hit_cnt++; next state IDLE.
- LOOKUP, miss: miss_cnt++. If c_ovalid and c_odirty, go to WB; otherwise go to FILL. mem_req is set at this edge.
- WB: mem_req=1, mem_wr=1, mem_addr={c_otag, index}, mem_wdata=c_oblock. Outputs are held stable until mem_ack; on mem_ack go to FILL with mem_req staying high and mem_wr falling.
- FILL: mem_req=1, mem_wr=0, mem_addr={latched tag, index}. On mem_ack:
  - c_wr=1 in that same cycle, c_tag=latched tag.
  - Load: c_dirty=0, c_block=mem_rdata, cpu_rdata <= lane of mem_rdata.
  - Store: c_dirty=1, c_block=merge(mem_rdata).
  - cpu_done <= 1, mem_req <= 0, next state IDLE.
  - A miss does not increment hit_cnt.
- Latency (edges counted from the edge that samples cpu_req): a hit gives cpu_done high after edge 2. A miss gives cpu_done high in the cycle after the final mem_ack.
- Back-to-back: IDLE accepts a new cpu_req in the same cycle cpu_done is high.
- cpu_req while busy is ignored; the requester holds it or re-issues it.
- Counters wrap at 2^CNT_W.

Decomposition:
- Shared package cache_pkg: state encodings; field constants TAG_W=8, IDX_W=5, OFF_W=2, WORD_W=16, BLK_W=64; address slice positions.
- One sub-module: blk_merge (combinational). Inputs are block, word, sel and en; output is the merged block. It is used for both hit-store and fill-store.

Test Plan:
- Cold load 0x1234 with memory fill 0x0004_0003_0002_0001 -> one FILL with mem_addr=0x0246; cpu_rdata=0x0003 (word 2); cache entry 6 written with tag 0x12, valid, clean; miss_cnt=1.
- Repeat load 0x1234 -> no mem_req; cpu_done after edge 2 with 0x0003; hit_cnt=1.
- Store 0xBEEF to 0x1230 (hit) -> c_wr with lane 0 replaced, c_dirty=1; a following load of 0x1230 returns 0xBEEF.
- Load 0x5634 (same index, dirty victim):
  - WB with mem_addr=0x0246 and mem_wdata=0x0004_0003_0002_BEEF.
  - Then FILL with mem_addr=0x0AC6.
  - mem_req stays high across the WB-to-FILL transition.
- Hold mem_ack low 10 cycles in FILL -> mem_req and mem_addr stay stable, cpu_busy=1, no c_wr; completion occurs on the first ack.
- Assert rstn low during WB -> next cycle state IDLE, mem_req=0, counters 0; a fresh load then misses cleanly.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry, address slicing and state encoding for the cache controller.
// The cache is 32 entries, direct-mapped, with one 64-bit block per entry.
package cache_pkg;

  localparam int TAG_W   = 8;
  localparam int IDX_W   = 5;
  localparam int OFF_W   = 2;
  localparam int WORD_W  = 16;
  localparam int BLK_W   = 64;
  localparam int ADDR_W  = 16;
  localparam int MADDR_W = TAG_W + IDX_W;

  // Bit positions of the fields inside the CPU byte address.
  localparam int TAG_LSB = 8;
  localparam int IDX_LSB = 3;
  localparam int OFF_LSB = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WB     = 2'd2,
    FILL   = 2'd3
  } ctrlState_e;

  function automatic logic [WORD_W-1:0] laneOf(input logic [BLK_W-1:0] blk,
                                               input logic [OFF_W-1:0] sel);
    return blk[{sel, 4'b0000} +: WORD_W];
  endfunction

endpackage

// File: rtl/blk_merge.sv
// Replaces one 16-bit lane of a block with a store word when enabled.
// The same merge is used for store hits and for store-miss line fills.
module blk_merge
  import cache_pkg::*;
(
  input  logic [BLK_W-1:0]  block,
  input  logic [WORD_W-1:0] word,
  input  logic [OFF_W-1:0]  sel,
  input  logic              en,
  output logic [BLK_W-1:0]  merged
);

  always_comb begin
    merged = block;
    if (en) merged[{sel, 4'b0000} +: WORD_W] = word;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Load/store controller in front of the direct-mapped cache: tag compare,
// store-hit writes, and dirty write-back plus block fill on a miss.
//
// state  | meaning
// IDLE   | waiting for cpu_req; latches the request when it arrives
// LOOKUP | cache read port shows the indexed line; decide hit or miss
// WB     | writing the dirty victim block back to memory
// FILL   | fetching the requested block; cache written on mem_ack
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic               cpu_busy,
  output logic               cpu_done,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic [IDX_W-1:0]   c_index,
  output logic [TAG_W-1:0]   c_tag,
  output logic               c_dirty,
  output logic [BLK_W-1:0]   c_block,
  output logic               c_wr,
  input  logic [TAG_W-1:0]   c_otag,
  input  logic [BLK_W-1:0]   c_oblock,
  input  logic               c_ovalid,
  input  logic               c_odirty,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]   mem_wdata,
  input  logic [BLK_W-1:0]   mem_rdata,
  input  logic               mem_ack,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  ctrlState_e state, nextState;

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [OFF_W-1:0]  reqOff;
  logic              reqWr;
  logic [WORD_W-1:0] reqWdata;
  logic [TAG_W-1:0]  vicTag;
  logic [BLK_W-1:0]  vicBlock;
  logic              hit;
  logic [BLK_W-1:0]  mergeSrc;
  logic              unusedAddrLsb;

  assign unusedAddrLsb = cpu_addr[0];
  assign hit = c_ovalid && (c_otag == reqTag);

  blk_merge uMerge (
    .block  (mergeSrc),
    .word   (reqWdata),
    .sel    (reqOff),
    .en     (reqWr),
    .merged (c_block)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (cpu_req) nextState = LOOKUP;
      LOOKUP: begin
        if (hit)                        nextState = IDLE;
        else if (c_ovalid && c_odirty)  nextState = WB;
        else                            nextState = FILL;
      end
      WB:      if (mem_ack) nextState = FILL;
      FILL:    if (mem_ack) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    cpu_busy  = (state != IDLE);
    c_index   = reqIdx;
    c_tag     = reqTag;
    c_wr      = 1'b0;
    c_dirty   = 1'b0;
    mergeSrc  = mem_rdata;
    mem_addr  = {reqTag, reqIdx};
    mem_wdata = vicBlock;
    case (state)
      LOOKUP: begin
        c_wr     = hit && reqWr;
        c_dirty  = 1'b1;
        mergeSrc = c_oblock;
      end
      WB:      mem_addr = {vicTag, reqIdx};
      FILL: begin
        c_wr    = mem_ack;
        c_dirty = reqWr;
      end
      default: ;
    endcase
  end

  // Victim tag/block are captured at the miss so WB outputs cannot drift.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      reqTag    <= '0;
      reqIdx    <= '0;
      reqOff    <= '0;
      reqWr     <= 1'b0;
      reqWdata  <= '0;
      vicTag    <= '0;
      vicBlock  <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            reqTag   <= cpu_addr[TAG_LSB +: TAG_W];
            reqIdx   <= cpu_addr[IDX_LSB +: IDX_W];
            reqOff   <= cpu_addr[OFF_LSB +: OFF_W];
            reqWr    <= cpu_wr;
            reqWdata <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_done <= 1'b1;
            hit_cnt  <= hit_cnt + CNT_W'(1);
            if (!reqWr) cpu_rdata <= laneOf(c_oblock, reqOff);
          end else begin
            miss_cnt <= miss_cnt + CNT_W'(1);
            mem_req  <= 1'b1;
            mem_wr   <= c_ovalid && c_odirty;
            vicTag   <= c_otag;
            vicBlock <= c_oblock;
          end
        end
        WB: begin
          if (mem_ack) mem_wr <= 1'b0;
        end
        FILL: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            cpu_done <= 1'b1;
            if (!reqWr) cpu_rdata <= laneOf(mem_rdata, reqOff);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
